// File: rtl/mips_mem_responder.sv
// Word-addressed memory responder for the multicycle MIPS datapath; answers each accepted
// request after LATENCY cycles. Optional address rejection: define MEM_ALIGN_CHECK_EN.
module mips_mem_responder #(
   parameter int unsigned DEPTH_LOG2 = 8,
   parameter int unsigned LATENCY    = 3,
   parameter logic [31:0] INIT_VAL   = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int unsigned Depth   = 1 << DEPTH_LOG2;
   localparam logic [3:0]  CntInit = 4'(LATENCY - 1);

   if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("mips_mem_responder: LATENCY must be in 1..15");
   end

   // Preload value used by the bench helper; the RAM itself is never touched by rst.
   function automatic logic [31:0] init_word();
      return INIT_VAL;
   endfunction

   typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

   state_e                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  we_q, we_d;
   logic [DEPTH_LOG2-1:0] idx_q, idx_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  rej_q, rej_d;
   logic                  ready_q, ready_d;
   logic                  rvalid_q, rvalid_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  rerr_q, rerr_d;
   logic                  mem_we;
   logic                  rej_in;
   logic [31:0]           mem_q [Depth];

`ifdef MEM_ALIGN_CHECK_EN
   assign rej_in = (req_addr[1:0] != 2'b00) || (req_addr[31:DEPTH_LOG2+2] != '0);
`else
   // Without checking, the byte offset and upper bits simply wrap away.
   logic unused_addr;
   assign unused_addr = ^{req_addr[31:DEPTH_LOG2+2], req_addr[1:0]};
   assign rej_in      = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      we_d     = we_q;
      idx_d    = idx_q;
      wdata_d  = wdata_q;
      rej_d    = rej_q;
      ready_d  = ready_q;
      rvalid_d = 1'b0;
      rdata_d  = rdata_q;
      rerr_d   = rerr_q;
      mem_we   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               we_d    = req_we;
               idx_d   = req_addr[DEPTH_LOG2+1:2];
               wdata_d = req_wdata;
               rej_d   = rej_in;
               cnt_d   = CntInit;
               ready_d = 1'b0;
               state_d = StBusy;
            end
         end
         StBusy: begin
            if (cnt_q == 4'd0) begin
               rvalid_d = 1'b1;
               state_d  = StResp;
               if (rej_q) begin
                  rdata_d = 32'h0;
                  rerr_d  = 1'b1;
               end else begin
                  rerr_d = 1'b0;
                  if (we_q) begin
                     mem_we  = 1'b1;
                     rdata_d = wdata_q;
                  end else begin
                     rdata_d = mem_q[idx_q];
                  end
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StResp: begin
            ready_d = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         cnt_q    <= 4'd0;
         we_q     <= 1'b0;
         idx_q    <= '0;
         wdata_q  <= 32'h0;
         rej_q    <= 1'b0;
         ready_q  <= 1'b1;
         rvalid_q <= 1'b0;
         rdata_q  <= 32'h0;
         rerr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         we_q     <= we_d;
         idx_q    <= idx_d;
         wdata_q  <= wdata_d;
         rej_q    <= rej_d;
         ready_q  <= ready_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         rerr_q   <= rerr_d;
      end
   end

   // A store pending at reset never commits: reset forces StIdle, so mem_we stays low.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[idx_q] <= wdata_q;
      end
   end

   assign req_ready  = ready_q;
   assign resp_valid = rvalid_q;
   assign resp_rdata = rdata_q;
   assign resp_err   = rerr_q;

endmodule
